// File: rtl/wb_pipe_stage.sv
// SPARC writeback: decodes op/op2/op3, formats load data, splits LDD into two writes.
// Latency 1 (registered outputs); ready drops for the one LDD_HI cycle and while reset is high.
module wb_pipe_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                WB_valid_in,
    output logic                WB_ready_out,
    input  logic [2*DATA_W-1:0] WB_alures_in,
    input  logic [2*DATA_W-1:0] WB_load_data_in,
    input  logic [RADDR_W-1:0]  WB_regD_in,
    input  logic [1:0]          WB_op_in,
    input  logic [2:0]          WB_op2_in,
    input  logic [5:0]          WB_op3_in,
    output logic                WB_reg_en,
    output logic [RADDR_W-1:0]  WB_regD_out,
    output logic [DATA_W-1:0]   WB_data_out,
    output logic [CNT_W-1:0]    WB_retired_out
);

    typedef enum logic {S_IDLE, S_LDD_HI} state_t;

    state_t              state_q, state_d;
    logic                reg_en_q, reg_en_d;
    logic [RADDR_W-1:0]  regd_q, regd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [RADDR_W-1:0]  odd_addr_q, odd_addr_d;
    logic [DATA_W-1:0]   odd_data_q, odd_data_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    logic                accept;
    logic                dec_wr;
    logic                dec_ldd;
    logic [RADDR_W-1:0]  dec_addr;
    logic [DATA_W-1:0]   dec_data;
    logic [DATA_W-1:0]   alu_lo;
    logic [DATA_W-1:0]   ld_lo;
    logic [DATA_W-1:0]   ld_hi;

    assign alu_lo = WB_alures_in[DATA_W-1:0];
    assign ld_lo  = WB_load_data_in[DATA_W-1:0];
    assign ld_hi  = WB_load_data_in[2*DATA_W-1:DATA_W];
    assign accept = WB_valid_in && WB_ready_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && dec_ldd) state_d = S_LDD_HI;
            S_LDD_HI: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        WB_ready_out = (state_q == S_IDLE) && !reset;
    end

    always_comb begin
        dec_wr   = 1'b0;
        dec_ldd  = 1'b0;
        dec_addr = WB_regD_in;
        dec_data = alu_lo;
        case (WB_op_in)
            2'b00: dec_wr = (WB_op2_in == 3'b100);
            2'b01: begin
                dec_wr   = 1'b1;
                dec_addr = RADDR_W'(15);
            end
            2'b10: dec_wr = !(WB_op3_in >= 6'h30 && WB_op3_in <= 6'h33);
            default: begin
                case (WB_op3_in)
                    6'h00: begin dec_wr = 1'b1; dec_data = ld_lo; end
                    6'h01: begin dec_wr = 1'b1; dec_data = {{(DATA_W-8){1'b0}}, ld_lo[7:0]}; end
                    6'h02: begin dec_wr = 1'b1; dec_data = {{(DATA_W-16){1'b0}}, ld_lo[15:0]}; end
                    6'h09: begin dec_wr = 1'b1; dec_data = {{(DATA_W-8){ld_lo[7]}}, ld_lo[7:0]}; end
                    6'h0A: begin dec_wr = 1'b1; dec_data = {{(DATA_W-16){ld_lo[15]}}, ld_lo[15:0]}; end
                    6'h03: begin
                        dec_wr   = 1'b1;
                        dec_ldd  = 1'b1;
                        dec_addr = {WB_regD_in[RADDR_W-1:1], 1'b0};
                        dec_data = ld_hi;
                    end
                    default: dec_wr = 1'b0;
                endcase
            end
        endcase
    end

    // Outputs clear every cycle nothing retires; r0 keeps address/data but drops the enable.
    always_comb begin
        reg_en_d   = 1'b0;
        regd_d     = '0;
        data_d     = '0;
        odd_addr_d = odd_addr_q;
        odd_data_d = odd_data_q;
        retired_d  = retired_q;
        if (state_q == S_LDD_HI) begin
            reg_en_d = (odd_addr_q != '0);
            regd_d   = odd_addr_q;
            data_d   = odd_data_q;
        end else if (accept) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (dec_wr) begin
                reg_en_d = (dec_addr != '0);
                regd_d   = dec_addr;
                data_d   = dec_data;
            end
            if (dec_ldd) begin
                odd_addr_d = {WB_regD_in[RADDR_W-1:1], 1'b1};
                odd_data_d = ld_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_en_q   <= 1'b0;
            regd_q     <= '0;
            data_q     <= '0;
            odd_addr_q <= '0;
            odd_data_q <= '0;
            retired_q  <= '0;
        end else begin
            reg_en_q   <= reg_en_d;
            regd_q     <= regd_d;
            data_q     <= data_d;
            odd_addr_q <= odd_addr_d;
            odd_data_q <= odd_data_d;
            retired_q  <= retired_d;
        end
    end

    assign WB_reg_en      = reg_en_q;
    assign WB_regD_out    = regd_q;
    assign WB_data_out    = data_q;
    assign WB_retired_out = retired_q;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage: hand-computed vectors checked with immediate assertions.
module tb_wb_pipe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        ready;
    logic [63:0] alures;
    logic [63:0] ld;
    logic [4:0]  rd;
    logic [1:0]  op;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic        reg_en;
    logic [4:0]  regd;
    logic [31:0] data;
    logic [31:0] retired;

    int vectors = 0;
    int errors  = 0;

    wb_pipe_stage #(.DATA_W(32), .RADDR_W(5), .CNT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .WB_valid_in     (valid),
        .WB_ready_out    (ready),
        .WB_alures_in    (alures),
        .WB_load_data_in (ld),
        .WB_regD_in      (rd),
        .WB_op_in        (op),
        .WB_op2_in       (op2),
        .WB_op3_in       (op3),
        .WB_reg_en       (reg_en),
        .WB_regD_out     (regd),
        .WB_data_out     (data),
        .WB_retired_out  (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic e_en, input logic [4:0] e_rd,
                          input logic [31:0] e_data, input logic [31:0] e_ret);
        chk({tag, ".en"},      {63'd0, reg_en}, {63'd0, e_en});
        chk({tag, ".regD"},    {59'd0, regd},   {59'd0, e_rd});
        chk({tag, ".data"},    {32'd0, data},   {32'd0, e_data});
        chk({tag, ".retired"}, {32'd0, retired}, {32'd0, e_ret});
    endtask

    // Drive one cycle of inputs at the falling edge, then sample 1 time unit past the rising edge.
    task automatic step(input logic v, input logic [1:0] o, input logic [2:0] o2, input logic [5:0] o3,
                        input logic [4:0] r, input logic [63:0] a, input logic [63:0] l);
        @(negedge clk);
        valid = v; op = o; op2 = o2; op3 = o3; rd = r; alures = a; ld = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; op = '0; op2 = '0; op3 = '0; rd = '0; alures = '0; ld = '0;
        step(1'b1, 2'b10, 3'd0, 6'h00, 5'd5, 64'h1, 64'h0);
        step(1'b0, 2'b00, 3'd0, 6'h00, 5'd0, 64'h0, 64'h0);
        chk_wr("reset", 1'b0, 5'd0, 32'h0, 32'd0);
        chk("reset.ready", {63'd0, ready}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset.ready", {63'd0, ready}, 64'd1);

        step(1'b1, 2'b10, 3'd0, 6'h00, 5'd5, 64'hDEAD_BEEF_1234_5678, 64'h0);
        chk_wr("add", 1'b1, 5'd5, 32'h1234_5678, 32'd1);
        step(1'b0, 2'b10, 3'd0, 6'h00, 5'd6, 64'h1, 64'h0);
        chk_wr("idle", 1'b0, 5'd0, 32'h0, 32'd1);

        step(1'b1, 2'b11, 3'd0, 6'h09, 5'd7, 64'h0, 64'h1111_2222_3333_1280);
        chk_wr("ldsb", 1'b1, 5'd7, 32'hFFFF_FF80, 32'd2);
        step(1'b1, 2'b11, 3'd0, 6'h01, 5'd7, 64'h0, 64'h1111_2222_3333_1280);
        chk_wr("ldub", 1'b1, 5'd7, 32'h0000_0080, 32'd3);
        step(1'b1, 2'b11, 3'd0, 6'h0A, 5'd8, 64'h0, 64'hFFFF_FFFF_0000_8001);
        chk_wr("ldsh", 1'b1, 5'd8, 32'hFFFF_8001, 32'd4);
        step(1'b1, 2'b11, 3'd0, 6'h02, 5'd8, 64'h0, 64'hFFFF_FFFF_0000_8001);
        chk_wr("lduh", 1'b1, 5'd8, 32'h0000_8001, 32'd5);
        step(1'b1, 2'b11, 3'd0, 6'h00, 5'd2, 64'h0, 64'h1234_5678_CAFE_F00D);
        chk_wr("ld", 1'b1, 5'd2, 32'hCAFE_F00D, 32'd6);

        // LDD, with a different instruction held on the bus during the LDD_HI cycle.
        step(1'b1, 2'b11, 3'd0, 6'h03, 5'd9, 64'h0, 64'hAAAA_AAAA_5555_5555);
        chk_wr("ldd.even", 1'b1, 5'd8, 32'hAAAA_AAAA, 32'd7);
        chk("ldd.even.ready", {63'd0, ready}, 64'd0);
        step(1'b1, 2'b10, 3'd0, 6'h00, 5'd3, 64'h77, 64'h0);
        chk_wr("ldd.odd", 1'b1, 5'd9, 32'h5555_5555, 32'd7);
        chk("ldd.odd.ready", {63'd0, ready}, 64'd1);
        step(1'b1, 2'b10, 3'd0, 6'h00, 5'd3, 64'h77, 64'h0);
        chk_wr("held_add", 1'b1, 5'd3, 32'h77, 32'd8);

        step(1'b1, 2'b10, 3'd0, 6'h00, 5'd0, 64'h99, 64'h0);
        chk_wr("add_r0", 1'b0, 5'd0, 32'h99, 32'd9);
        step(1'b1, 2'b11, 3'd0, 6'h03, 5'd0, 64'h0, 64'h0000_1111_0000_2222);
        chk_wr("ldd_r0.even", 1'b0, 5'd0, 32'h0000_1111, 32'd10);
        step(1'b0, 2'b00, 3'd0, 6'h00, 5'd0, 64'h0, 64'h0);
        chk_wr("ldd_r0.odd", 1'b1, 5'd1, 32'h0000_2222, 32'd10);

        step(1'b1, 2'b01, 3'd0, 6'h00, 5'd3, 64'h400, 64'h0);
        chk_wr("call", 1'b1, 5'd15, 32'h400, 32'd11);
        step(1'b1, 2'b00, 3'b010, 6'h00, 5'd4, 64'h55, 64'h0);
        chk_wr("branch", 1'b0, 5'd0, 32'h0, 32'd12);
        step(1'b1, 2'b00, 3'b100, 6'h00, 5'd4, 64'h1234_5000, 64'h0);
        chk_wr("sethi", 1'b1, 5'd4, 32'h1234_5000, 32'd13);
        step(1'b1, 2'b11, 3'd0, 6'h04, 5'd6, 64'h66, 64'h66);
        chk_wr("st", 1'b0, 5'd0, 32'h0, 32'd14);
        step(1'b1, 2'b10, 3'd0, 6'h31, 5'd6, 64'h66, 64'h0);
        chk_wr("wr_state", 1'b0, 5'd0, 32'h0, 32'd15);
        step(1'b1, 2'b10, 3'd0, 6'h34, 5'd6, 64'h66, 64'h0);
        chk_wr("op3_34", 1'b1, 5'd6, 32'h66, 32'd16);

        // Reset landing on the LDD_HI cycle must drop the odd write.
        step(1'b1, 2'b11, 3'd0, 6'h03, 5'd11, 64'h0, 64'h0BAD_0BAD_0F0F_0F0F);
        chk_wr("ldd2.even", 1'b1, 5'd10, 32'h0BAD_0BAD, 32'd17);
        @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk_wr("rst_ldd_hi", 1'b0, 5'd0, 32'h0, 32'd0);
        chk("rst_ldd_hi.ready", {63'd0, ready}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release.ready", {63'd0, ready}, 64'd1);
        step(1'b0, 2'b00, 3'd0, 6'h00, 5'd0, 64'h0, 64'h0);
        chk_wr("no_odd_after_rst", 1'b0, 5'd0, 32'h0, 32'd0);
        step(1'b1, 2'b10, 3'd0, 6'h00, 5'd12, 64'h5A, 64'h0);
        chk_wr("add_after_rst", 1'b1, 5'd12, 32'h5A, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wb_pipe_stage.md
# wb_pipe_stage

Parametrised writeback stage for the SPARC pipeline. It decodes the retiring instruction's op/op2/op3 fields to decide whether, where and what to write into the integer register file. It formats sub-word load results and splits LDD into two register-file writes with upstream back-pressure. It sits between the memory stage and the register-file write port, and all of its outputs are registered.

## Interface
Parameters:
- DATA_W, 32: register width; result buses are 2*DATA_W.
- RADDR_W, 5: register address width.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- WB_valid_in  in  1  instruction present from memory stage.
- WB_ready_out  out  1  stage can accept; combinational from state.
- WB_alures_in  in  2*DATA_W  ALU result; low DATA_W bits used.
- WB_load_data_in  in  2*DATA_W  load data, right-aligned.
- WB_regD_in  in  RADDR_W  destination register rd.
- WB_op_in  in  2  SPARC op field.
- WB_op2_in  in  3  op2 field (format 2).
- WB_op3_in  in  6  op3 field (format 3).
- WB_reg_en  out  1  register-file write enable.
- WB_regD_out  out  RADDR_W  register-file write address.
- WB_data_out  out  DATA_W  register-file write data.
- WB_retired_out  out  CNT_W  count of accepted instructions.

## Operation
- An instruction is accepted when WB_valid_in && WB_ready_out at the clk edge. Inputs are ignored otherwise.
- Write decision and data for an accepted instruction:
  - op=00, op2=100 (SETHI): write rd with alures.
  - op=00, other op2: no write.
  - op=01 (CALL): write register 15 with alures.
  - op=10, op3 in 6'h30..6'h33 (WR state registers): no write.
  - op=10, other op3: write rd with alures.
  - op=11, op3=00 (LD): write load_data[DATA_W-1:0].
  - op=11, op3=01 (LDUB): zero-extend [7:0].
  - op=11, op3=02 (LDUH): zero-extend [15:0].
  - op=11, op3=09 (LDSB): sign-extend [7:0].
  - op=11, op3=0A (LDSH): sign-extend [15:0].
  - op=11, op3=03 (LDD): two writes, see below.
  - op=11, any other op3 (stores, atomics not supported): no write.
- Writes to register 0 are suppressed: WB_reg_en=0, while address and data still show the computed values.
- "No write" means WB_reg_en=0, WB_regD_out=0, WB_data_out=0.
- FSM states:
  - IDLE: WB_ready_out=1.
  - LDD_HI: WB_ready_out=0.
- IDLE -> LDD_HI when an LDD is accepted. The even register {rd[RADDR_W-1:1],0} is written with load_data[2*DATA_W-1:DATA_W]. The odd register (even+1) and load_data[DATA_W-1:0] are latched.
- LDD_HI -> IDLE unconditionally on the next edge, which issues the odd-register write. rd[0] is ignored.
- WB_retired_out increments by 1 per accepted instruction, including no-write instructions. LDD counts once. The counter wraps modulo 2^CNT_W.

## Timing
- Latency 1: an instruction accepted at edge N drives WB_reg_en/WB_regD_out/WB_data_out during cycle N..N+1, i.e. the outputs are registered at edge N.
- LDD accepted at edge N: even write visible after edge N, WB_ready_out=0 in that cycle. Odd write visible after edge N+1, WB_ready_out=1 again.
- When no instruction is accepted at an edge, the outputs after that edge are WB_reg_en=0, WB_regD_out=0, WB_data_out=0 (no hold of stale writes).
- Back-to-back non-LDD instructions sustain one write per cycle.
- Reset, taking effect at the edge where reset=1:
  - WB_reg_en=0, WB_regD_out=0, WB_data_out=0, WB_retired_out=0, state IDLE.
  - WB_ready_out=0 while reset is high.
  - Reset during LDD_HI discards the pending odd write.
- WB_valid_in during LDD_HI is not accepted. Upstream must hold the instruction.

## Test plan
- ADD (op=10, op3=00), rd=5, alures=0x0000_0000_1234_5678 -> one cycle later: reg_en=1, regD=5, data=0x12345678, retired=1.
- LDSB, rd=7, load_data low byte 0x80 -> data=0xFFFFFF80. LDUB with the same data -> data=0x00000080.
- LDD, rd=9, load_data=0xAAAA_AAAA_5555_5555:
  - cycle 1: regD=8, data=0xAAAAAAAA, ready=0.
  - cycle 2: regD=9, data=0x55555555, ready=1.
  - retired increments by 1.
- rd=0 ADD -> reg_en=0. LDD rd=0 -> cycle 1 reg_en=0, then cycle 2 reg_en=1, regD=1.
- CALL alures=0x400 -> regD=15, data=0x400. Branch (op=00, op2=010) and ST (op=11, op3=04) -> reg_en=0, regD=0, data=0.
- Reset asserted in the LDD_HI cycle -> no odd write afterwards, all outputs 0, retired=0. After reset deasserts, ready=1.
